// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package riscv_loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned LEN_W = 16;

endpackage

// File: rtl/instr_mem_array.sv
// Word-addressed instruction RAM: synchronous write, asynchronous read.
module instr_mem_array #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [31:0]                wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [31:0]                rdata
);

  logic [31:0] mem_q [DEPTH];

  // Contents survive reset; the loader masks stale words until a frame verifies.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a checksummed program frame from a byte stream into instruction RAM
// and serves fetches once the frame verifies.
module instr_mem_loader
  import riscv_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        cpu_run,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  loader_state_t      state_q, state_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [LEN_W-1:0]   n_words_q, n_words_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        word_q, word_d;
  logic [7:0]         csum_q, csum_d;
  logic [LEN_W-1:0]   words_loaded_q, words_loaded_d;
  logic               byte_ready_q, byte_ready_d;
  logic               cpu_run_q, cpu_run_d;
  logic               load_error_q, load_error_d;

  logic               accept_c;
  logic               mem_we_c;
  logic [ADDR_W-1:0]  mem_waddr_c;
  logic [31:0]        mem_wdata_c;
  logic [31:0]        mem_rdata_c;
  logic               fetch_ok_c;

  assign accept_c = byte_valid & byte_ready_q;

  // Frame parser: next state, assembly, checksum and RAM write strobe.
  always_comb begin
    state_d        = state_q;
    len_lo_d       = len_lo_q;
    n_words_d      = n_words_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded_q;
    mem_we_c       = 1'b0;
    mem_waddr_c    = words_loaded_q[ADDR_W-1:0];
    mem_wdata_c    = {byte_data, word_q};

    if (accept_c) begin
      case (state_q)
        LEN_LO: begin
          len_lo_d = byte_data;
          csum_d   = csum_q ^ byte_data;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          n_words_d = {byte_data, len_lo_q};
          csum_d    = csum_q ^ byte_data;
          if (32'(n_words_d) > DEPTH) begin
            state_d = ERROR;
          end else if (n_words_d == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          csum_d     = csum_q ^ byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: word_d[7:0]   = byte_data;
            2'd1: word_d[15:8]  = byte_data;
            2'd2: word_d[23:16] = byte_data;
            default: begin
              mem_we_c       = 1'b1;
              words_loaded_d = words_loaded_q + 16'd1;
              if (words_loaded_d == n_words_q) begin
                state_d = CSUM;
              end
            end
          endcase
        end
        CSUM: begin
          state_d = (byte_data == csum_q) ? RUN : ERROR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    byte_ready_d = (state_d != RUN);
    cpu_run_d    = (state_d == RUN);
    load_error_d = (state_d == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LEN_LO;
      len_lo_q       <= '0;
      n_words_q      <= '0;
      byte_cnt_q     <= '0;
      word_q         <= '0;
      csum_q         <= '0;
      words_loaded_q <= '0;
      byte_ready_q   <= 1'b1;
      cpu_run_q      <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_lo_q       <= len_lo_d;
      n_words_q      <= n_words_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      words_loaded_q <= words_loaded_d;
      byte_ready_q   <= byte_ready_d;
      cpu_run_q      <= cpu_run_d;
      load_error_q   <= load_error_d;
    end
  end

  instr_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (mem_waddr_c),
    .wdata (mem_wdata_c),
    .raddr (PC[ADDR_W+1:2]),
    .rdata (mem_rdata_c)
  );

  // Only aligned, in-range fetches of a verified program see RAM; all else is a NOP.
  assign fetch_ok_c  = cpu_run_q && (PC[1:0] == 2'b00) && (PC[31:ADDR_W+2] == '0);
  assign Instruction = fetch_ok_c ? mem_rdata_c : NOP_INSTR;

  assign byte_ready   = byte_ready_q;
  assign cpu_run      = cpu_run_q;
  assign load_error   = load_error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader against a frame-level reference model.
module tb_instr_mem_loader;
  import riscv_loader_pkg::*;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        cpu_run;
  logic        load_error;
  logic [15:0] words_loaded;

  always #5 clk = ~clk;

  instr_mem_loader #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .PC           (PC),
    .Instruction  (Instruction),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        run;
    logic        err;
    logic        rdy;
    logic [15:0] wl;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic        probe_req;
  int          n_pass  = 0;
  int          n_total = 0;
  int          gap_max = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic        m_run;
  logic        m_err;
  logic [15:0] m_wl;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops one expectation whenever a probe is presented.
  always @(negedge clk) begin
    if (probe_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: got probe expected queued entry");
      end else begin
        mon_e = exp_q.pop_front();
        check32({mon_e.name, ".instr"},  Instruction,        mon_e.instr);
        check32({mon_e.name, ".run"},    32'(cpu_run),       32'(mon_e.run));
        check32({mon_e.name, ".err"},    32'(load_error),    32'(mon_e.err));
        check32({mon_e.name, ".ready"},  32'(byte_ready),    32'(mon_e.rdy));
        check32({mon_e.name, ".words"},  32'(words_loaded),  32'(mon_e.wl));
      end
    end
  end

  function automatic logic [31:0] ref_fetch(input logic [31:0] pc);
    logic [31:0] idx;
    idx = pc / 4;
    if (m_run && (pc % 4 == 0) && (idx < DEPTH)) return ref_mem[idx[5:0]];
    return NOP_INSTR;
  endfunction

  task automatic probe(input string name, input logic [31:0] pc);
    exp_t e;
    e.name  = name;
    e.instr = ref_fetch(pc);
    e.run   = m_run;
    e.err   = m_err;
    e.rdy   = !m_run;
    e.wl    = m_wl;
    exp_q.push_back(e);
    PC = pc;
    probe_req = 1'b1;
    @(posedge clk); #1;
    probe_req = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'(($urandom % 255) + 1);
    @(posedge clk); #1;
    reset      = 1'b0;
    byte_valid = 1'b0;
    m_run = 1'b0;
    m_err = 1'b0;
    m_wl  = 16'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int waited;
    gap    = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    waited = 0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (byte_ready !== 1'b1) begin
      n_total++;
      $display("FAIL accept_timeout: got ready=%b expected 1 within 50 cycles", byte_ready);
      byte_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_range(input logic [7:0] f[$], input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(f[i]);
  endtask

  function automatic void make_frame(input logic [31:0] w[$], input bit bad, output logic [7:0] f[$]);
    logic [7:0] x;
    f = {};
    f.push_back(8'(w.size()));
    f.push_back(8'(w.size() / 256));
    for (int i = 0; i < w.size(); i++)
      for (int k = 0; k < 4; k++) f.push_back(8'(w[i] >> (8 * k)));
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
    f.push_back(bad ? (x ^ 8'h5A) : x);
  endfunction

  // Frame-level outcome: length check, word image, checksum verdict.
  task automatic model_frame(input logic [7:0] f[$]);
    int n;
    logic [7:0] x;
    n = int'(f[0]) + 256 * int'(f[1]);
    if (n > DEPTH) begin
      m_err = 1'b1; m_run = 1'b0; m_wl = 16'd0;
      return;
    end
    for (int i = 0; i < n; i++)
      ref_mem[i[5:0]] = {f[5 + 4*i], f[4 + 4*i], f[3 + 4*i], f[2 + 4*i]};
    x = 8'h00;
    for (int i = 0; i < 2 + 4*n; i++) x ^= f[i];
    m_wl = 16'(n);
    if (f[2 + 4*n] == x) m_run = 1'b1;
    else m_err = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] w[$];
    logic [31:0] w64[$];
    logic [7:0]  f[$];
    logic [31:0] pc;

    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; PC = 32'h0; probe_req = 1'b0;
    m_run = 1'b0; m_err = 1'b0; m_wl = 16'd0;
    @(posedge clk); #1;
    do_reset();
    probe("reset_state", 32'h0);

    // Full-depth frame, no gaps
    w64 = {};
    for (int i = 0; i < DEPTH; i++) w64.push_back($urandom);
    w64[2] = NOP_INSTR;
    make_frame(w64, 1'b0, f);
    send_range(f, 0, f.size());
    model_frame(f);
    probe("full_last", 32'h0000_00FC);
    probe("full_oob", 32'h0000_0100);
    probe("full_misalign", 32'h0000_0002);
    probe("full_high", 32'h8000_0000);
    for (int i = 0; i < DEPTH; i++) probe("full_img", 32'(4 * i));
    byte_valid = 1'b1; byte_data = 8'hFF;
    repeat (4) @(posedge clk);
    #1; byte_valid = 1'b0;
    probe("run_ignores_bytes", 32'h0000_0010);

    // Same frame with random valid gaps: identical image expected
    do_reset();
    gap_max = 3;
    send_range(f, 0, f.size());
    model_frame(f);
    for (int i = 0; i < DEPTH; i++) probe("gap_img", 32'(4 * i));
    for (int i = 0; i < 12; i++) begin
      pc = $urandom & 32'h0000_01FF;
      probe("rand_pc", pc);
    end

    // Two-word program, checksum correct
    do_reset();
    gap_max = 1;
    w = {32'h00a00513, 32'h00300593};
    make_frame(w, 1'b0, f);
    send_range(f, 0, f.size() - 1);
    m_wl = 16'd2;
    probe("t1_pre_csum", 32'h0);
    send_byte(f[f.size() - 1]);
    model_frame(f);
    probe("t1_pc0", 32'h0);
    probe("t1_pc4", 32'h4);
    probe("t1_pc8", 32'h8);

    // Same program, bad checksum; error drains further bytes
    do_reset();
    make_frame(w, 1'b1, f);
    send_range(f, 0, f.size());
    model_frame(f);
    probe("t2_err", 32'h0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    probe("t2_drain", 32'h4);

    // Length DEPTH+1 rejected at LEN_HI
    do_reset();
    f = {8'h41, 8'h00};
    send_range(f, 0, 2);
    model_frame(f);
    probe("t3_len_err", 32'h0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    probe("t3_drain", 32'h0);

    // Empty program
    do_reset();
    w = {};
    make_frame(w, 1'b0, f);
    send_range(f, 0, f.size());
    model_frame(f);
    probe("t4_oob", 32'h0000_0400);
    probe("t4_misalign", 32'h0000_0006);
    probe("t4_high", 32'hFFFF_FFFC);

    // Reset mid-frame, then a fresh frame
    do_reset();
    w = {$urandom, $urandom};
    make_frame(w, 1'b0, f);
    send_range(f, 0, 8);
    ref_mem[0] = w[0];
    m_wl = 16'd1;
    probe("t5_partial", 32'h0);
    do_reset();
    probe("t5_after_reset", 32'h0);
    w = {$urandom, $urandom};
    make_frame(w, 1'b0, f);
    send_range(f, 0, f.size());
    model_frame(f);
    probe("t5_pc0", 32'h0);
    probe("t5_pc4", 32'h4);

    @(posedge clk); #1;
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
